// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction-time game blocks.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package reaction_timer_pkg;

    localparam int TIME_W = 13;
    localparam logic [TIME_W-1:0] BEST_NONE = 13'h1FFF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RAND,
        GO,
        DONE
    } rt_state_t;

    // Smaller of two millisecond times; used for the best-time record.
    function automatic logic [TIME_W-1:0] min_time(input logic [TIME_W-1:0] a,
                                                  input logic [TIME_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/reaction_timer_if.sv
// Game control/result bundle between the round controller and its environment.
// Latency: n/a (wires only).
// Backpressure: none; all controls are one-cycle pulses or levels.
interface reaction_timer_if;
    import reaction_timer_pkg::*;

    logic              start;
    logic              get_rand;
    logic              tick_1ms;
    logic              btn;
    logic              led_go;
    logic [TIME_W-1:0] react_ms;
    logic              result_valid;
    logic              foul;
    logic              timeout;
    logic [TIME_W-1:0] best_ms;

    // Environment side: drives round controls and the player button.
    modport master (
        output start, get_rand, tick_1ms, btn,
        input  led_go, react_ms, result_valid, foul, timeout, best_ms
    );

    // Controller side.
    modport slave (
        input  start, get_rand, tick_1ms, btn,
        output led_go, react_ms, result_valid, foul, timeout, best_ms
    );

endinterface

// File: rtl/btn_edge_sync.sv
// Synchronises an asynchronous button level and emits a one-cycle press pulse on its rising edge.
// Latency: pulse is high in the cycle after the second synchroniser flop captures the high level.
// Backpressure: none; a held button produces exactly one pulse.
module btn_edge_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_press
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Two-flop synchroniser plus a delayed copy of the synchronised level for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_press = r_sync2 & ~r_prev;

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time round controller: waits for the random delay, lights GO, times the press, keeps best time.
// Latency: results register on the FSM edge; best_ms follows one edge later; press adds 2 sync cycles.
// Backpressure: none; results hold in DONE until the next start.
module reaction_timer
    import reaction_timer_pkg::*;
#(
    parameter int TIMEOUT_MS = 2000
) (
    input  logic           clk,
    input  logic           rst_n,
    reaction_timer_if.slave bus
);

    localparam logic [TIME_W-1:0] LP_TIMEOUT = TIME_W'(TIMEOUT_MS);

    logic              w_press;

    rt_state_t         r_state;
    logic [TIME_W-1:0] r_cnt;
    logic              r_led_go;
    logic [TIME_W-1:0] r_react_ms;
    logic              r_result_valid;
    logic              r_foul;
    logic              r_timeout;
    logic [TIME_W-1:0] r_best_ms;
    logic              r_best_pend;

    btn_edge_sync u_btn_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_btn   (bus.btn),
        .o_press (w_press)
    );

    // Round FSM with registered outputs; start overrides every other event in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_led_go       <= 1'b0;
            r_react_ms     <= '0;
            r_result_valid <= 1'b0;
            r_foul         <= 1'b0;
            r_timeout      <= 1'b0;
            r_best_ms      <= BEST_NONE;
            r_best_pend    <= 1'b0;
        end else begin
            // A valid result from the previous edge folds into the record here, one edge later
            r_best_pend <= 1'b0;
            if (r_best_pend) begin
                r_best_ms <= min_time(r_best_ms, r_react_ms);
            end

            if (bus.start) begin
                r_state        <= WAIT_RAND;
                r_cnt          <= '0;
                r_led_go       <= 1'b0;
                r_react_ms     <= '0;
                r_result_valid <= 1'b0;
                r_foul         <= 1'b0;
                r_timeout      <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    WAIT_RAND: begin
                        // An early press beats a same-cycle get_rand
                        if (w_press) begin
                            r_foul         <= 1'b1;
                            r_result_valid <= 1'b1;
                            r_state        <= DONE;
                        end else if (bus.get_rand) begin
                            r_led_go <= 1'b1;
                            r_cnt    <= '0;
                            r_state  <= GO;
                        end
                    end
                    GO: begin
                        // A press beats a same-cycle tick, so that tick is not counted
                        if (w_press) begin
                            r_react_ms     <= r_cnt;
                            r_led_go       <= 1'b0;
                            r_result_valid <= 1'b1;
                            r_best_pend    <= 1'b1;
                            r_state        <= DONE;
                        end else if (bus.tick_1ms) begin
                            // The tick that brings the count to the limit ends the round
                            if (r_cnt == LP_TIMEOUT - 1'b1) begin
                                r_cnt          <= LP_TIMEOUT;
                                r_timeout      <= 1'b1;
                                r_react_ms     <= LP_TIMEOUT;
                                r_led_go       <= 1'b0;
                                r_result_valid <= 1'b1;
                                r_state        <= DONE;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        r_state <= DONE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.led_go       = r_led_go;
    assign bus.react_ms     = r_react_ms;
    assign bus.result_valid = r_result_valid;
    assign bus.foul         = r_foul;
    assign bus.timeout      = r_timeout;
    assign bus.best_ms      = r_best_ms;

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer: two instances (default limit and a 20 ms limit) share stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_reaction_timer;
    import reaction_timer_pkg::*;

    typedef struct packed {
        logic [TIME_W-1:0] react;
        logic              foul;
        logic              to;
        logic [TIME_W-1:0] best;
    } exp_t;

    logic              clk;
    logic              rst_n;
    int                n_cmp;
    int                n_err;
    exp_t              sb_q[$];
    exp_t              e;
    logic [TIME_W-1:0] model_best;
    bit                got;

    reaction_timer_if ifa ();
    reaction_timer_if ifb ();

    reaction_timer #(.TIMEOUT_MS(2000)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    reaction_timer #(.TIMEOUT_MS(20))   dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    assign ifb.start    = ifa.start;
    assign ifb.get_rand = ifa.get_rand;
    assign ifb.tick_1ms = ifa.tick_1ms;
    assign ifb.btn      = ifa.btn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want summary first");
        $fatal(1);
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        ifa.start = 1'b1; cyc(1); ifa.start = 1'b0;
    endtask

    task automatic pulse_rand();
        ifa.get_rand = 1'b1; cyc(1); ifa.get_rand = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ifa.tick_1ms = 1'b1; cyc(1); ifa.tick_1ms = 1'b0; cyc(1);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cyc(1); rst_n = 1'b1;
        model_best = BEST_NONE;
        sb_q.delete();
    endtask

    task automatic push_exp(input int t, input bit f, input bit to, input bit upd_best);
        exp_t x;
        if (upd_best && (TIME_W'(t) < model_best)) model_best = TIME_W'(t);
        x.react = TIME_W'(t); x.foul = f; x.to = to; x.best = model_best;
        sb_q.push_back(x);
    endtask

    task automatic wait_rv(input bit on_b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((on_b ? ifb.result_valid : ifa.result_valid) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (ifa.led_go !== 1'b0) begin n_err++; $display("FAIL rst_led_go: got %b want 0", ifa.led_go); end
        n_cmp++; if (ifa.result_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", ifa.result_valid); end
        n_cmp++; if (ifa.react_ms !== 13'd0) begin n_err++; $display("FAIL rst_react: got %0d want 0", ifa.react_ms); end
        n_cmp++; if ({ifa.foul, ifa.timeout} !== 2'b00) begin n_err++; $display("FAIL rst_flags: got %b want 00", {ifa.foul, ifa.timeout}); end
        n_cmp++; if (ifa.best_ms !== BEST_NONE) begin n_err++; $display("FAIL rst_best: got %h want 1fff", ifa.best_ms); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_best = BEST_NONE;
    endtask

    task automatic test_normal();
        pulse_start();
        cyc(10);
        pulse_rand();
        @(negedge clk);
        n_cmp++; if (ifa.led_go !== 1'b1) begin n_err++; $display("FAIL normal_go_on: got %b want 1", ifa.led_go); end
        ticks(137);
        push_exp(137, 1'b0, 1'b0, 1'b1);
        ifa.btn = 1'b1;
        wait_rv(1'b0, got);
        n_cmp++; if (!got) begin n_err++; $display("FAIL normal_valid: got 0 want 1 within 40 cycles"); end
        e = sb_q.pop_front();
        n_cmp++; if (ifa.react_ms !== e.react) begin n_err++; $display("FAIL normal_react: got %0d want %0d", ifa.react_ms, e.react); end
        n_cmp++; if ({ifa.foul, ifa.timeout, ifa.led_go} !== 3'b000) begin n_err++; $display("FAIL normal_flags: got %b want 000", {ifa.foul, ifa.timeout, ifa.led_go}); end
        n_cmp++; if (ifa.best_ms !== BEST_NONE) begin n_err++; $display("FAIL normal_best_early: got %0d want 8191", ifa.best_ms); end
        @(negedge clk);
        n_cmp++; if (ifa.best_ms !== e.best) begin n_err++; $display("FAIL normal_best: got %0d want %0d", ifa.best_ms, e.best); end
        ifa.btn = 1'b0;
        cyc(3);
    endtask

    task automatic test_foul();
        pulse_start();
        cyc(3);
        push_exp(0, 1'b1, 1'b0, 1'b0);
        ifa.btn = 1'b1;
        wait_rv(1'b0, got);
        n_cmp++; if (!got) begin n_err++; $display("FAIL foul_valid: got 0 want 1 within 40 cycles"); end
        e = sb_q.pop_front();
        ifa.btn = 1'b0;
        cyc(2);
        pulse_rand();
        cyc(2);
        @(negedge clk);
        n_cmp++; if (ifa.foul !== e.foul) begin n_err++; $display("FAIL foul_flag: got %b want %b", ifa.foul, e.foul); end
        n_cmp++; if (ifa.react_ms !== e.react) begin n_err++; $display("FAIL foul_react: got %0d want %0d", ifa.react_ms, e.react); end
        n_cmp++; if (ifa.led_go !== 1'b0) begin n_err++; $display("FAIL foul_led_go: got %b want 0", ifa.led_go); end
        n_cmp++; if (ifa.best_ms !== e.best) begin n_err++; $display("FAIL foul_best: got %0d want %0d", ifa.best_ms, e.best); end
        cyc(1);
    endtask

    task automatic test_timeout();
        do_reset();
        pulse_start();
        cyc(2);
        pulse_rand();
        ticks(19);
        @(negedge clk);
        n_cmp++; if ({ifb.result_valid, ifb.led_go} !== 2'b01) begin n_err++; $display("FAIL to_before_limit: got %b want 01", {ifb.result_valid, ifb.led_go}); end
        push_exp(20, 1'b0, 1'b1, 1'b0);
        ticks(1);
        @(negedge clk);
        e = sb_q.pop_front();
        n_cmp++; if ({ifb.result_valid, ifb.timeout, ifb.foul, ifb.led_go} !== {2'b11, e.foul, 1'b0}) begin n_err++; $display("FAIL to_flags: got %b want 1100", {ifb.result_valid, ifb.timeout, ifb.foul, ifb.led_go}); end
        n_cmp++; if (ifb.react_ms !== e.react) begin n_err++; $display("FAIL to_react: got %0d want %0d", ifb.react_ms, e.react); end
        @(negedge clk);
        n_cmp++; if (ifb.best_ms !== e.best) begin n_err++; $display("FAIL to_best: got %0d want %0d", ifb.best_ms, e.best); end
        ifa.btn = 1'b1;
        cyc(6);
        @(negedge clk);
        n_cmp++; if ({ifb.react_ms, ifb.timeout, ifb.foul} !== {e.react, 1'b1, 1'b0}) begin n_err++; $display("FAIL to_late_press: got %0d/%b/%b want %0d/1/0", ifb.react_ms, ifb.timeout, ifb.foul, e.react); end
        ifa.btn = 1'b0;
        cyc(3);
    endtask

    task automatic test_simultaneous();
        do_reset();
        // press and get_rand sampled on the same edge
        pulse_start();
        cyc(3);
        ifa.btn = 1'b1;
        cyc(2);
        pulse_rand();
        @(negedge clk);
        n_cmp++; if ({ifa.result_valid, ifa.foul, ifa.led_go} !== 3'b110) begin n_err++; $display("FAIL sim_rand_foul: got %b want 110", {ifa.result_valid, ifa.foul, ifa.led_go}); end
        ifa.btn = 1'b0;
        cyc(3);
        // press on the same edge as the 6th tick
        pulse_start();
        cyc(2);
        pulse_rand();
        ticks(5);
        push_exp(5, 1'b0, 1'b0, 1'b1);
        ifa.btn = 1'b1;
        cyc(2);
        ifa.tick_1ms = 1'b1; cyc(1); ifa.tick_1ms = 1'b0;
        wait_rv(1'b0, got);
        e = sb_q.pop_front();
        n_cmp++; if (!got || ifa.react_ms !== e.react) begin n_err++; $display("FAIL sim_tick_react: got %0d want %0d", ifa.react_ms, e.react); end
        @(negedge clk);
        n_cmp++; if (ifa.best_ms !== e.best) begin n_err++; $display("FAIL sim_tick_best: got %0d want %0d", ifa.best_ms, e.best); end
        ifa.btn = 1'b0;
        cyc(3);
        // start on the same edge as a press
        pulse_start();
        cyc(2);
        ifa.btn = 1'b1;
        cyc(2);
        pulse_start();
        @(negedge clk);
        n_cmp++; if ({ifa.result_valid, ifa.foul, ifa.led_go} !== 3'b000) begin n_err++; $display("FAIL sim_start_press: got %b want 000", {ifa.result_valid, ifa.foul, ifa.led_go}); end
        cyc(1);
        pulse_rand();
        @(negedge clk);
        n_cmp++; if (ifa.led_go !== 1'b1) begin n_err++; $display("FAIL sim_start_waitrand: got %b want 1", ifa.led_go); end
        ifa.btn = 1'b0;
        cyc(3);
    endtask

    task automatic test_best();
        int rounds[3];
        rounds = '{300, 180, 250};
        do_reset();
        for (int r = 0; r < 3; r++) begin
            pulse_start();
            cyc(2);
            pulse_rand();
            ticks(rounds[r]);
            push_exp(rounds[r], 1'b0, 1'b0, 1'b1);
            ifa.btn = 1'b1;
            wait_rv(1'b0, got);
            e = sb_q.pop_front();
            n_cmp++; if (!got || ifa.react_ms !== e.react) begin n_err++; $display("FAIL best_round%0d_react: got %0d want %0d", r, ifa.react_ms, e.react); end
            @(negedge clk);
            n_cmp++; if (ifa.best_ms !== e.best) begin n_err++; $display("FAIL best_round%0d_best: got %0d want %0d", r, ifa.best_ms, e.best); end
            ifa.btn = 1'b0;
            cyc(3);
        end
    endtask

    task automatic test_held_button();
        ifa.btn = 1'b1;
        cyc(4);
        pulse_start();
        cyc(2);
        pulse_rand();
        ticks(4);
        cyc(3);
        @(negedge clk);
        n_cmp++; if ({ifa.result_valid, ifa.led_go} !== 2'b01) begin n_err++; $display("FAIL held_no_result: got %b want 01", {ifa.result_valid, ifa.led_go}); end
        ifa.btn = 1'b0;
        cyc(3);
        push_exp(4, 1'b0, 1'b0, 1'b1);
        ifa.btn = 1'b1;
        wait_rv(1'b0, got);
        e = sb_q.pop_front();
        n_cmp++; if (!got || ifa.react_ms !== e.react) begin n_err++; $display("FAIL held_react: got %0d want %0d", ifa.react_ms, e.react); end
        @(negedge clk);
        n_cmp++; if (ifa.best_ms !== e.best) begin n_err++; $display("FAIL held_best: got %0d want %0d", ifa.best_ms, e.best); end
        ifa.btn = 1'b0;
        cyc(3);
    endtask

    task automatic test_async_reset();
        pulse_start();
        cyc(2);
        pulse_rand();
        ticks(3);
        @(negedge clk);
        n_cmp++; if (ifa.led_go !== 1'b1) begin n_err++; $display("FAIL areset_pre_go: got %b want 1", ifa.led_go); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({ifa.led_go, ifa.result_valid, ifa.foul, ifa.timeout} !== 4'b0000) begin n_err++; $display("FAIL areset_flags: got %b want 0000", {ifa.led_go, ifa.result_valid, ifa.foul, ifa.timeout}); end
        n_cmp++; if (ifa.react_ms !== 13'd0) begin n_err++; $display("FAIL areset_react: got %0d want 0", ifa.react_ms); end
        n_cmp++; if (ifa.best_ms !== BEST_NONE) begin n_err++; $display("FAIL areset_best: got %h want 1fff", ifa.best_ms); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_best = BEST_NONE;
        cyc(3);
        pulse_rand();
        ticks(2);
        ifa.btn = 1'b1;
        cyc(5);
        @(negedge clk);
        n_cmp++; if ({ifa.led_go, ifa.result_valid} !== 2'b00) begin n_err++; $display("FAIL areset_idle: got %b want 00", {ifa.led_go, ifa.result_valid}); end
        ifa.btn = 1'b0;
        cyc(3);
        pulse_start();
        cyc(1);
        pulse_rand();
        @(negedge clk);
        n_cmp++; if (ifa.led_go !== 1'b1) begin n_err++; $display("FAIL areset_restart: got %b want 1", ifa.led_go); end
        cyc(1);
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        model_best   = BEST_NONE;
        rst_n        = 1'b0;
        ifa.start    = 1'b0;
        ifa.get_rand = 1'b0;
        ifa.tick_1ms = 1'b0;
        ifa.btn      = 1'b0;
        test_reset();
        test_normal();
        test_foul();
        test_timeout();
        test_simultaneous();
        test_best();
        test_held_button();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
